// File: rtl/arf_pkg.sv
// -----------------------------------------------------------------------------
// arf_pkg
// Shared constants and types for the architectural register file retire path.
//   NUM_REG        number of architectural registers
//   NUM_REG_LOG2   register index width
//   REG_SIZE       register data width
//   arf_reg_t      register index type
//   arf_data_t     register data type
//   retire_entry_t one queued retire write {reg_idx, data}
// -----------------------------------------------------------------------------
package arf_pkg;
  localparam int NUM_REG      = 32;
  localparam int NUM_REG_LOG2 = $clog2(NUM_REG);
  localparam int REG_SIZE     = 32;

  typedef logic [NUM_REG_LOG2-1:0] arf_reg_t;
  typedef logic [REG_SIZE-1:0]     arf_data_t;

  // The field cannot be called "reg" (keyword), so it is reg_idx.
  typedef struct packed {
    arf_reg_t  reg_idx;
    arf_data_t data;
  } retire_entry_t;
endpackage

// File: rtl/retire_fifo.sv
// -----------------------------------------------------------------------------
// retire_fifo
// Circular buffer that accepts up to two pushes and performs at most one pop
// per cycle. The caller guarantees that at least i_push_cnt slots are free.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_push_cnt                number of entries to push (0..2)
//   i_a_reg/i_a_data          first (older) entry, written at the write pointer
//   i_b_reg/i_b_data          second entry, written one slot after the first
//   i_pop                     remove the head entry
//   o_head_reg/o_head_data    current head entry
//   o_count                   number of occupied entries
//   o_rptr                    head slot index (oldest entry)
//   o_ent_valid               per-slot occupied flag
//   o_ent_reg/o_ent_data      flattened per-slot contents, slot i at [i*W +: W]
// -----------------------------------------------------------------------------
module retire_fifo
  import arf_pkg::*;
#(
  parameter int RW    = arf_pkg::NUM_REG_LOG2,
  parameter int DW    = arf_pkg::REG_SIZE,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            i_push_cnt,
  input  logic [RW-1:0]         i_a_reg,
  input  logic [DW-1:0]         i_a_data,
  input  logic [RW-1:0]         i_b_reg,
  input  logic [DW-1:0]         i_b_data,
  input  logic                  i_pop,
  output logic [RW-1:0]         o_head_reg,
  output logic [DW-1:0]         o_head_data,
  output logic [AW:0]           o_count,
  output logic [AW-1:0]         o_rptr,
  output logic [DEPTH-1:0]      o_ent_valid,
  output logic [DEPTH*RW-1:0]   o_ent_reg,
  output logic [DEPTH*DW-1:0]   o_ent_data
);

  logic [RW-1:0]    r_reg  [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [AW-1:0]    w_wptr1;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign w_wptr1 = r_wptr + 1'b1;

  // Control state: pointers, count and occupied flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // Pop is applied first; a push never targets the head slot because
      // the producer only pushes into free slots.
      if (i_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + 1'b1;
      end
      if (i_push_cnt != 2'd0) begin
        r_valid[r_wptr] <= 1'b1;
      end
      if (i_push_cnt == 2'd2) begin
        r_valid[w_wptr1] <= 1'b1;
      end
      r_wptr  <= r_wptr + AW'(i_push_cnt);
      r_count <= r_count + (AW+1)'(i_push_cnt) - (AW+1)'(i_pop);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by r_valid.
  always_ff @(posedge clk) begin
    if (!rst && (i_push_cnt != 2'd0)) begin
      r_reg[r_wptr]  <= i_a_reg;
      r_data[r_wptr] <= i_a_data;
    end
    if (!rst && (i_push_cnt == 2'd2)) begin
      r_reg[w_wptr1]  <= i_b_reg;
      r_data[w_wptr1] <= i_b_data;
    end
  end

  assign o_head_reg  = r_reg[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_count     = r_count;
  assign o_rptr      = r_rptr;
  assign o_ent_valid = r_valid;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign o_ent_reg[gi*RW +: RW]  = r_reg[gi];
      assign o_ent_data[gi*DW +: DW] = r_data[gi];
    end
  endgenerate

endmodule

// File: rtl/arf_retire_sequencer.sv
// -----------------------------------------------------------------------------
// arf_retire_sequencer
// Buffers up to two committed results per cycle and drains one per cycle into
// the architectural register file retire port. Reports whether a queried
// register still has a queued write.
// Optional build macro: ARF_RETIRE_FWD_EN -- when defined, rsX_fwd_data carries
// the youngest queued value for rsX; otherwise rsX_fwd_data is tied to 0.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   commit0_* / commit1_*             commit lanes (lane 0 older than lane 1)
//   commit_ready                      both lanes may be accepted this cycle
//   arf_we / arf_waddr / arf_wdata    retire write to the register file
//   rs1, rs2                          operand-read queries
//   rs1_pending, rs2_pending          queued write exists for the query
//   rs1_fwd_data, rs2_fwd_data        youngest queued value for the query
//   occupancy                         current FIFO entry count
// -----------------------------------------------------------------------------
module arf_retire_sequencer
  import arf_pkg::*;
#(
  parameter int  NUM_REG      = arf_pkg::NUM_REG,
  parameter int  REG_SIZE     = arf_pkg::REG_SIZE,
  parameter int  DEPTH        = 4,
  localparam int NUM_REG_LOG2 = $clog2(NUM_REG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit0_valid,
  input  logic [NUM_REG_LOG2-1:0]  commit0_reg,
  input  logic [REG_SIZE-1:0]      commit0_data,
  input  logic                     commit1_valid,
  input  logic [NUM_REG_LOG2-1:0]  commit1_reg,
  input  logic [REG_SIZE-1:0]      commit1_data,
  output logic                     commit_ready,
  output logic                     arf_we,
  output logic [NUM_REG_LOG2-1:0]  arf_waddr,
  output logic [REG_SIZE-1:0]      arf_wdata,
  input  logic [NUM_REG_LOG2-1:0]  rs1,
  input  logic [NUM_REG_LOG2-1:0]  rs2,
  output logic                     rs1_pending,
  output logic                     rs2_pending,
  output logic [REG_SIZE-1:0]      rs1_fwd_data,
  output logic [REG_SIZE-1:0]      rs2_fwd_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = NUM_REG_LOG2;

  logic                  w_keep0;
  logic                  w_keep1;
  logic [1:0]            w_push_cnt;
  logic [RW-1:0]         w_a_reg;
  logic [REG_SIZE-1:0]   w_a_data;
  logic [AW:0]           w_count;
  logic [AW-1:0]         w_rptr;
  logic [DEPTH-1:0]      w_ent_valid;
  logic [DEPTH*RW-1:0]   w_ent_reg_flat;
  logic [DEPTH*REG_SIZE-1:0] w_ent_data_flat;
  logic [RW-1:0]         w_head_reg;
  logic [REG_SIZE-1:0]   w_head_data;
  logic [DEPTH-1:0]      w_m1;
  logic [DEPTH-1:0]      w_m2;

  // Writes to x0 are architecturally invisible and never take a slot.
  assign w_keep0 = commit0_valid && (commit0_reg != '0);
  assign w_keep1 = commit1_valid && (commit1_reg != '0);

  // Conservative: two free slots required regardless of how many lanes fire.
  assign commit_ready = !rst && ((DEPTH - int'(w_count)) >= 2);

  assign w_push_cnt = commit_ready ? ({1'b0, w_keep0} + {1'b0, w_keep1}) : 2'd0;

  // Compact the surviving lanes so the first survivor lands in the first slot.
  assign w_a_reg  = w_keep0 ? commit0_reg  : commit1_reg;
  assign w_a_data = w_keep0 ? commit0_data : commit1_data;

  // Retire write is suppressed during reset so a flush never leaks a write.
  assign arf_we    = !rst && (w_count != '0);
  assign arf_waddr = w_head_reg;
  assign arf_wdata = w_head_data;
  assign occupancy = w_count;

  retire_fifo #(
    .RW    (RW),
    .DW    (REG_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push_cnt  (w_push_cnt),
    .i_a_reg     (w_a_reg),
    .i_a_data    (w_a_data),
    .i_b_reg     (commit1_reg),
    .i_b_data    (commit1_data),
    .i_pop       (arf_we),
    .o_head_reg  (w_head_reg),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_rptr      (w_rptr),
    .o_ent_valid (w_ent_valid),
    .o_ent_reg   (w_ent_reg_flat),
    .o_ent_data  (w_ent_data_flat)
  );

  // Per-slot match against each query; the head counts while it is written.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign w_m1[gi] = w_ent_valid[gi] && (w_ent_reg_flat[gi*RW +: RW] == rs1);
      assign w_m2[gi] = w_ent_valid[gi] && (w_ent_reg_flat[gi*RW +: RW] == rs2);
    end
  endgenerate

  assign rs1_pending = (rs1 != '0) && (|w_m1);
  assign rs2_pending = (rs2 != '0) && (|w_m2);

`ifdef ARF_RETIRE_FWD_EN
  logic [AW-1:0]       w_age_idx  [DEPTH];
  logic [REG_SIZE-1:0] w_ent_data [DEPTH];

  // w_age_idx[k] is the slot holding the k-th oldest entry.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      assign w_age_idx[gi]  = w_rptr + AW'(gi);
      assign w_ent_data[gi] = w_ent_data_flat[gi*REG_SIZE +: REG_SIZE];
    end
  endgenerate

  // Walk oldest to youngest; the last match wins, giving the youngest value.
  always_comb begin
    rs1_fwd_data = '0;
    rs2_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rs1_pending && w_m1[w_age_idx[k]]) rs1_fwd_data = w_ent_data[w_age_idx[k]];
      if (rs2_pending && w_m2[w_age_idx[k]]) rs2_fwd_data = w_ent_data[w_age_idx[k]];
    end
  end
`else
  assign rs1_fwd_data = '0;
  assign rs2_fwd_data = '0;

  logic w_unused;
  assign w_unused = ^{w_rptr, w_ent_data_flat};
`endif

endmodule

// File: tb/tb_arf_retire_sequencer.sv
module tb_arf_retire_sequencer;
  import arf_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit0_valid = 1'b0;
  logic [4:0]  commit0_reg   = '0;
  logic [31:0] commit0_data  = '0;
  logic        commit1_valid = 1'b0;
  logic [4:0]  commit1_reg   = '0;
  logic [31:0] commit1_data  = '0;
  logic        commit_ready;
  logic        arf_we;
  logic [4:0]  arf_waddr;
  logic [31:0] arf_wdata;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        rs1_pending, rs2_pending;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  arf_retire_sequencer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .commit0_valid (commit0_valid),
    .commit0_reg   (commit0_reg),
    .commit0_data  (commit0_data),
    .commit1_valid (commit1_valid),
    .commit1_reg   (commit1_reg),
    .commit1_data  (commit1_data),
    .commit_ready  (commit_ready),
    .arf_we        (arf_we),
    .arf_waddr     (arf_waddr),
    .arf_wdata     (arf_wdata),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_pending   (rs1_pending),
    .rs2_pending   (rs2_pending),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_data  (rs2_fwd_data),
    .occupancy     (occupancy)
  );

  // Reference model: mq holds queue contents in commit order; exp_q is the
  // scoreboard of register-file writes still expected from the DUT.
  retire_entry_t mq[$];
  retire_entry_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  started = 1'b0;
  bit  last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_query(input logic [4:0] rs, output bit pend, output logic [31:0] data);
    pend = 1'b0;
    data = '0;
    if (rs != 5'd0) begin
      foreach (mq[i]) begin
        if (mq[i].reg_idx == rs) begin
          pend = 1'b1;
          data = mq[i].data;
        end
      end
    end
  endfunction

  task automatic set_lanes(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                           input bit v1, input logic [4:0] r1, input logic [31:0] d1);
    commit0_valid = v0; commit0_reg = r0; commit0_data = d0;
    commit1_valid = v1; commit1_reg = r1; commit1_data = d1;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the
  // model across the coming edge. Inputs change #1 after the edge.
  task automatic cycle();
    bit exp_ready;
    bit p;
    logic [31:0] fd;
    retire_entry_t e;
    @(negedge clk);
    exp_ready = !rst && ((DEPTH - mq.size()) >= 2);
    chk("commit_ready", {31'd0, commit_ready}, {31'd0, exp_ready});
    chk("arf_we", {31'd0, arf_we}, {31'd0, (!rst && mq.size() != 0)});
    if (!rst && started) begin
      chk("occupancy", {29'd0, occupancy}, mq.size());
      chk("occ_bound", {31'd0, (occupancy <= DEPTH)}, 32'd1);
      model_query(rs1, p, fd);
      chk("rs1_pending", {31'd0, rs1_pending}, {31'd0, p});
`ifdef ARF_RETIRE_FWD_EN
      chk("rs1_fwd", rs1_fwd_data, fd);
`else
      chk("rs1_fwd", rs1_fwd_data, 32'd0);
`endif
      model_query(rs2, p, fd);
      chk("rs2_pending", {31'd0, rs2_pending}, {31'd0, p});
`ifdef ARF_RETIRE_FWD_EN
      chk("rs2_fwd", rs2_fwd_data, fd);
`else
      chk("rs2_fwd", rs2_fwd_data, 32'd0);
`endif
    end
    #1;
    last_acc = exp_ready;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      started = 1'b1;
    end else begin
      if (mq.size() != 0) void'(mq.pop_front());
      if (exp_ready) begin
        if (commit0_valid && commit0_reg != 5'd0) begin
          e.reg_idx = commit0_reg; e.data = commit0_data;
          mq.push_back(e); exp_q.push_back(e);
        end
        if (commit1_valid && commit1_reg != 5'd0) begin
          e.reg_idx = commit1_reg; e.data = commit1_data;
          mq.push_back(e); exp_q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented retire write must match the oldest expected one.
  always @(negedge clk) begin : monitor
    retire_entry_t e;
    if (arf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got r%0d=%0h expected no write (t=%0t)", arf_waddr, arf_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("arf_waddr", {27'd0, arf_waddr}, {27'd0, e.reg_idx});
        chk("arf_wdata", arf_wdata, e.data);
        $display("retire r%0d <= %08h", arf_waddr, arf_wdata);
      end
    end
  end

  initial begin
    bit hold;
    // Reset, then release.
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // Single lane-0 commit, minimum latency and pending.
    set_lanes(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    rs1 = 5'd5;
    cycle();
    set_lanes(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    cycle();
    cycle();

    // Two-wide flood: ready must drop at occupancy 3, drain in order.
    for (int i = 0; i < 8; ) begin
      set_lanes(1, 5'(2*i+1), 32'(2*i+1), 1, 5'(2*i+2), 32'(2*i+2));
      rs2 = 5'(2*i+1);
      cycle();
      if (last_acc) i++;
    end
    set_lanes(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    repeat (6) cycle();

    // x0 on lane 0 is dropped; lane 1 takes the first slot.
    set_lanes(1, 5'd0, 32'h55, 1, 5'd7, 32'h77);
    rs1 = 5'd0;
    rs2 = 5'd7;
    cycle();
    set_lanes(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    repeat (2) cycle();

    // WAW on r9: youngest value forwarded, both writes drain in order.
    set_lanes(1, 5'd9, 32'h10, 1, 5'd9, 32'h20);
    rs2 = 5'd9;
    cycle();
    set_lanes(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    repeat (3) cycle();

    // Reset with occupancy 3: queued entries must vanish unwritten.
    set_lanes(1, 5'd11, 32'hB, 1, 5'd12, 32'hC);
    cycle();
    set_lanes(1, 5'd13, 32'hD, 1, 5'd14, 32'hE);
    rs1 = 5'd14;
    cycle();
    set_lanes(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (4) cycle();

    // Randomized traffic with small register range to force collisions.
    hold = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!hold) begin
        set_lanes($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
      end
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 149) == 0);
      cycle();
      hold = !last_acc && (commit0_valid || commit1_valid);
    end
    rst = 1'b0;
    set_lanes(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    repeat (8) cycle();
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arf_retire_sequencer.md
Name: arf_retire_sequencer

Overview:
- Sits between the reorder-buffer commit stage and the architectural register file's single retire write port.
- Accepts up to two committed results per cycle, buffers them in order in a small FIFO, and drains one per cycle to the register file.
- Tells the operand-read stage when an architectural register has a write still queued, so the stage never reads a stale value.
- Optionally forwards the newest queued value.

Parameters:
- NUM_REG, 32, number of architectural registers.
- NUM_REG_LOG2, $clog2(NUM_REG), register index width.
- REG_SIZE, 32, data width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- commit0_valid  in  1  lane 0 result valid (older)
- commit0_reg  in  NUM_REG_LOG2  lane 0 destination
- commit0_data  in  REG_SIZE  lane 0 value
- commit1_valid  in  1  lane 1 result valid (younger)
- commit1_reg  in  NUM_REG_LOG2  lane 1 destination
- commit1_data  in  REG_SIZE  lane 1 value
- commit_ready  out  1  both lanes may be accepted this cycle
- arf_we  out  1  retire write valid (drives register file retire_valid)
- arf_waddr  out  NUM_REG_LOG2  retire destination
- arf_wdata  out  REG_SIZE  retire data
- rs1  in  NUM_REG_LOG2  read query 1
- rs2  in  NUM_REG_LOG2  read query 2
- rs1_pending  out  1  queued write exists for rs1
- rs2_pending  out  1  queued write exists for rs2
- rs1_fwd_data  out  REG_SIZE  newest queued value for rs1
- rs2_fwd_data  out  REG_SIZE  newest queued value for rs2
- occupancy  out  $clog2(DEPTH)+1  current entry count

Behaviour:
- Reset: all entries flushed; read/write pointers and count cleared.
  - arf_we=0, occupancy=0, pending=0, fwd_data=0.
  - commit_ready is forced 0 while rst=1 and returns to 1 in the first cycle after rst deasserts.
  - Commits presented during rst are ignored.
  - Reset mid-drain discards all queued entries; none are written to the register file.
- commit_ready is combinational: 1 when (DEPTH - occupancy) >= 2. The check is conservative and does not depend on how many lanes are valid.
- Accept: on a clock edge with commit_ready=1, each valid lane whose reg != 0 is enqueued.
  - Lane 0 is written before lane 1.
  - Valid lanes with reg == 0 are dropped and consume no slot.
  - commit1_valid with commit0_valid=0 is legal; lane 1 takes the first free slot.
- Valid with commit_ready=0: the lanes are not accepted. The producer must hold them stable. No side effects.
- Drain: the FIFO head drives arf_we/arf_waddr/arf_wdata combinationally.
  - arf_we = (occupancy != 0).
  - The head pops on every edge where arf_we=1; the register file writes on the same edge.
  - Minimum latency: commit accepted at edge N appears on arf_* in cycle N+1 and is architecturally written at edge N+1.
- Simultaneous enqueue of 2 and dequeue of 1: net count +1. Pointers wrap modulo DEPTH.
- occupancy never exceeds DEPTH. Overflow is impossible by construction; a bench assertion checks it.
- Pending:
  - rsX_pending=1 iff rsX != 0 and any occupied entry, including the head being written this cycle, has reg == rsX.
  - Commits arriving in the current cycle are not visible until the next cycle.
- WAW: duplicate registers in the queue drain in commit order; the youngest write wins in the register file.

Optional Feature:
- Macro: ARF_RETIRE_FWD_EN.
- Defined: rsX_fwd_data = data of the youngest occupied entry matching rsX, searched from tail back to head. Valid whenever rsX_pending=1; otherwise 0. Consumers use fwd_data instead of stalling.
- Undefined: no match-priority logic; rsX_fwd_data tied to 0. Pending still computed; consumers stall until pending clears.
- Ports are identical in both builds.

Decomposition:
- Package arf_pkg:
  - NUM_REG, NUM_REG_LOG2, REG_SIZE constants.
  - typedef arf_reg_t (register index).
  - typedef arf_data_t.
  - typedef struct packed retire_entry_t {arf_reg_t reg; arf_data_t data;}.
- Sub-module retire_fifo: dual-push, single-pop circular buffer.
  - Outputs: head, occupancy, and a flattened entry/valid view for the pending/forward search.
- The top-level module holds the x0 filter, ready logic and query logic.

Test Plan:
- Reset release -> cycle 1: commit_ready=1, arf_we=0, occupancy=0.
- Lane 0 (r5, 0xDEADBEEF) at edge N:
  - cycle N+1: arf_we=1, arf_waddr=5, arf_wdata=0xDEADBEEF, rs1=5 gives rs1_pending=1.
  - cycle N+2: arf_we=0, rs1_pending=0.
- Two-wide commits every cycle, (r1,1)/(r2,2), (r3,3)/(r4,4), ... with DEPTH=4:
  - commit_ready drops to 0 at occupancy 3.
  - Drain order on arf_* is r1, r2, r3, r4, ...
  - occupancy never exceeds 4.
- Lane 0 (r0, 0x55) plus lane 1 (r7, 0x77) -> only r7 enqueued, occupancy=1; rs1=0 gives rs1_pending=0.
- WAW with ARF_RETIRE_FWD_EN:
  - Lane 0 (r9, 0x10), lane 1 (r9, 0x20) -> rs2=9 gives rs2_pending=1, rs2_fwd_data=0x20.
  - Drain writes 0x10 then 0x20; pending clears after the second write.
- rst asserted with occupancy=3 -> next cycle occupancy=0, arf_we=0; no further register-file writes occur.
